// File: rtl/aes192_ks_ctrl_if.sv
// Key-schedule controller bus: key offer, expansion-engine link and the shared round-key read port.
// The slave modport is the controller's view; the master modport is the system or engine side.
interface aes192_ks_ctrl_if;
    logic [191:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         exp_start;
    logic [191:0] exp_key;
    logic [127:0] exp_subkey;
    logic         exp_valid;
    logic         keys_ready;
    logic         exp_err;
    logic         req0_valid;
    logic         req1_valid;
    logic [3:0]   req0_idx;
    logic [3:0]   req1_idx;
    logic         req0_ready;
    logic         req1_ready;
    logic         rd_valid;
    logic         rd_id;
    logic [127:0] rd_data;
    logic         rd_oob;

    modport slave (
        input  key_in, key_valid, exp_subkey, exp_valid,
        input  req0_valid, req1_valid, req0_idx, req1_idx,
        output key_ready, exp_start, exp_key, keys_ready, exp_err,
        output req0_ready, req1_ready, rd_valid, rd_id, rd_data, rd_oob
    );

    modport master (
        output key_in, key_valid, exp_subkey, exp_valid,
        output req0_valid, req1_valid, req0_idx, req1_idx,
        input  key_ready, exp_start, exp_key, keys_ready, exp_err,
        input  req0_ready, req1_ready, rd_valid, rd_id, rd_data, rd_oob
    );
endinterface

// File: rtl/aes192_ks_ctrl.sv
// AES-192 key-expansion sequencer: starts the engine, stores round keys 0..12, serves two readers.
// Optional AES_KS_ZEROIZE_EN clears stale key material on rekey and on engine failure.
module aes192_ks_ctrl #(
    parameter int unsigned NRK         = 13,
    parameter int unsigned WDOG_CYCLES = 32
) (
    input logic             clk,
    input logic             reset,
    aes192_ks_ctrl_if.slave bus
);
    localparam int unsigned WdogW  = $clog2(WDOG_CYCLES + 1);
    localparam int unsigned NBeats = NRK - 1;

    typedef enum logic [2:0] {StIdle, StStart, StCollect, StReady, StErr} state_e;

    state_e             state_q, state_d;
    logic [191:0]       exp_key_q, exp_key_d;
    logic [127:0]       rf_q [NRK];
    logic [127:0]       rf_d [NRK];
    logic [3:0]         beat_q, beat_d;
    logic [WdogW-1:0]   wdog_q, wdog_d;
    logic               err_q, err_d;
    logic               rr_last_q, rr_last_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_id_q, rd_id_d;
    logic               rd_oob_q, rd_oob_d;
    logic [127:0]       rd_data_q, rd_data_d;

    logic               key_ready, key_accept;
    logic               gnt0, gnt1;
    logic [3:0]         gnt_idx;

    assign key_ready  = (state_q == StIdle) || (state_q == StReady) || (state_q == StErr);
    assign key_accept = key_ready && bus.key_valid;

    // Round-robin: rr_last_q is the port granted most recently (reset 1 so port 0 wins first).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StReady && !key_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt1 = !rr_last_q;
                gnt0 = rr_last_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        gnt_idx    = gnt1 ? bus.req1_idx : bus.req0_idx;
        rr_last_d  = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : rr_last_q);
        rd_valid_d = gnt0 || gnt1;
        rd_id_d    = gnt1;
        rd_oob_d   = rd_valid_d && (gnt_idx > 4'(NRK - 1));
        rd_data_d  = '0;
        if (rd_valid_d && !rd_oob_d) begin
            rd_data_d = rf_q[gnt_idx];
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_key_d = exp_key_q;
        rf_d      = rf_q;
        beat_d    = beat_q;
        wdog_d    = wdog_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle, StReady, StErr: begin
                if (key_accept) begin
                    exp_key_d = bus.key_in;
                    rf_d[0]   = bus.key_in[191:64];
`ifdef AES_KS_ZEROIZE_EN
                    for (int i = 1; i < NRK; i++) rf_d[i] = '0;
`endif
                    err_d     = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                beat_d  = '0;
                wdog_d  = '0;
                state_d = StCollect;
            end
            StCollect: begin
                wdog_d = wdog_q + 1'b1;
                if (bus.exp_valid && beat_q < 4'(NBeats)) begin
                    rf_d[beat_q + 4'd1] = bus.exp_subkey;
                    beat_d              = beat_q + 4'd1;
                end
                if (bus.exp_valid && beat_q == 4'(NBeats - 1)) begin
                    state_d = StReady;
                end else if (wdog_q == WdogW'(WDOG_CYCLES - 1)) begin
                    state_d = StErr;
                    err_d   = 1'b1;
`ifdef AES_KS_ZEROIZE_EN
                    for (int i = 0; i < NRK; i++) rf_d[i] = '0;
                    exp_key_d = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            exp_key_q  <= '0;
            for (int i = 0; i < NRK; i++) rf_q[i] <= '0;
            beat_q     <= '0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
            rr_last_q  <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            exp_key_q  <= exp_key_d;
            rf_q       <= rf_d;
            beat_q     <= beat_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            rr_last_q  <= rr_last_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_oob_q   <= rd_oob_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.key_ready  = key_ready;
    assign bus.exp_start  = (state_q == StStart);
    assign bus.exp_key    = exp_key_q;
    assign bus.keys_ready = (state_q == StReady);
    assign bus.exp_err    = err_q;
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_id      = rd_id_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_oob     = rd_oob_q;
endmodule
